// File: rtl/bubble_pagebuf_mc.sv
// Double-buffered multi-channel page buffer between the SPI page loader and the
// bubble DOUT pins. Banks cycle EMPTY -> FULL -> ACTIVE -> EMPTY via commit/acquire/release.

module bubble_pagebuf_lane #(
    parameter int BITS_PER_CH = 1024,
    parameter int BIT_W       = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [BIT_W-1:0] waddr,
    input  logic             wdata,
    input  logic             re,
    input  logic             rbank,
    input  logic [BIT_W-1:0] raddr,
    output logic             rdata
);
    // Both banks share one array; the bank pointer is the address MSB.
    logic mem [0:2*BITS_PER_CH-1];

    always_ff @(posedge clk) begin
        if (we) mem[{wbank, waddr}] <= wdata;
        if (re) rdata <= mem[{rbank, raddr}];
    end
endmodule

module bubble_pagebuf_mc #(
    parameter int   NUM_CH      = 4,
    parameter int   BITS_PER_CH = 1024,
    parameter bit   IDLE_LEVEL  = 1'b1,
    localparam int  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 0,
    localparam int  BIT_W       = $clog2(BITS_PER_CH),
    localparam int  WA_W        = BIT_W + CH_W
) (
    input  logic              MCLK,
    input  logic              RST,
    input  logic              nWRCLKEN,
    input  logic [WA_W-1:0]   WR_ADDR,
    input  logic              WR_DATA,
    input  logic              WR_COMMIT,
    output logic              WR_READY,
    input  logic              RD_START,
    input  logic              RD_END,
    input  logic              nRDCLKEN,
    input  logic [BIT_W-1:0]  RD_BITNUM,
    input  logic              nNOBUBBLE,
    input  logic              CH_SWAP,
    output logic [NUM_CH-1:0] DOUT,
    output logic              RD_VALID,
    output logic              UNDERRUN
);
    localparam int CH_WS = (CH_W > 0) ? CH_W : 1;

    typedef enum logic [1:0] {EMPTY, FULL, ACTIVE} bank_st_t;

    bank_st_t [1:0] st_q, st_d;
    logic wbank, wbank_d, rbank, rbank_d;
    logic rd_valid, rd_valid_d, underrun, underrun_d;

    always_ff @(posedge MCLK) begin
        if (RST) begin
            st_q     <= {EMPTY, EMPTY};
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            rd_valid <= 1'b0;
            underrun <= 1'b0;
        end else begin
            st_q     <= st_d;
            wbank    <= wbank_d;
            rbank    <= rbank_d;
            rd_valid <= rd_valid_d;
            underrun <= underrun_d;
        end
    end

    // Commit and release touch different banks, so both may fire in one cycle.
    always_comb begin
        st_d       = st_q;
        wbank_d    = wbank;
        rbank_d    = rbank;
        rd_valid_d = rd_valid;
        underrun_d = underrun;
        if (WR_COMMIT && st_q[wbank] == EMPTY) begin
            st_d[wbank] = FULL;
            wbank_d     = ~wbank;
        end
        if (RD_END && st_q[rbank] == ACTIVE) begin
            st_d[rbank] = EMPTY;
            rbank_d     = ~rbank;
            rd_valid_d  = 1'b0;
        end else if (RD_START) begin
            if (st_q[rbank] == FULL) begin
                st_d[rbank] = ACTIVE;
                rd_valid_d  = 1'b1;
            end else if (st_q[rbank] != ACTIVE) begin
                underrun_d = 1'b1;
            end
        end
    end

    assign WR_READY = (st_q[wbank] == EMPTY);
    assign RD_VALID = rd_valid;
    assign UNDERRUN = underrun;

    logic [BIT_W-1:0]  wr_bit;
    logic [CH_WS-1:0]  wr_ch;
    logic              wr_en;
    logic              rd_go;
    logic [NUM_CH-1:0] rd_data;

    assign wr_bit = WR_ADDR[WA_W-1:CH_W];
    assign wr_en  = ~nWRCLKEN & WR_READY;
    assign rd_go  = ~nRDCLKEN;

    if (CH_W > 0) begin : g_ch
        assign wr_ch = WR_ADDR[CH_WS-1:0];
    end else begin : g_noch
        assign wr_ch = '0;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        bubble_pagebuf_lane #(.BITS_PER_CH(BITS_PER_CH), .BIT_W(BIT_W)) u_lane (
            .clk   (MCLK),
            .we    (wr_en && (wr_ch == CH_WS'(i))),
            .wbank (wbank),
            .waddr (wr_bit),
            .wdata (WR_DATA),
            .re    (rd_go),
            .rbank (rbank),
            .raddr (RD_BITNUM),
            .rdata (rd_data[i])
        );
    end

    // Stage 1 carries the strobe, its qualification and the swap select beside the RAM read.
    logic s1_go, s1_ok, s1_swap;
    logic [NUM_CH-1:0] rd_rev;

    always_comb begin
        rd_rev = '0;
        for (int i = 0; i < NUM_CH; i++) rd_rev[i] = rd_data[NUM_CH-1-i];
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            s1_go   <= 1'b0;
            s1_ok   <= 1'b0;
            s1_swap <= 1'b0;
            DOUT    <= {NUM_CH{IDLE_LEVEL}};
        end else begin
            s1_go <= rd_go;
            if (rd_go) begin
                s1_ok   <= rd_valid & nNOBUBBLE;
                s1_swap <= CH_SWAP;
            end
            if (s1_go) begin
                if (!s1_ok)       DOUT <= {NUM_CH{IDLE_LEVEL}};
                else if (s1_swap) DOUT <= rd_rev;
                else              DOUT <= rd_data;
            end
        end
    end
endmodule
